// File: rtl/rfg_axis_cmd_decoder_if.sv
// Byte-stream ingress/egress and register-file strobe bundle around the command decoder.
// slave = decoder side, master = stream source / register file / egress side.
interface rfg_axis_cmd_decoder_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [7:0]            m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [ADDR_WIDTH-1:0] rfg_address;
    logic [7:0]            rfg_write_value;
    logic                  rfg_write;
    logic                  rfg_read;
    logic                  rfg_read_valid;
    logic [7:0]            rfg_read_value;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready, rfg_read_valid, rfg_read_value,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, rfg_address, rfg_write_value,
               rfg_write, rfg_read
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready, rfg_read_valid, rfg_read_value,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, rfg_address, rfg_write_value,
               rfg_write, rfg_read
    );
endinterface

// File: rtl/rfg_axis_cmd_decoder.sv
// Parses header/addr/len byte frames into register write/read strobes; write strobe 1 cycle after byte,
// read >=3 cycles/byte. Ingress always ready (dummy bytes dropped during reads); egress holds data until tready.
module rfg_axis_cmd_decoder #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    rfg_axis_cmd_decoder_if.slave  bus,
    output logic                   busy,
    output logic                   err_bad_header
);

    typedef enum logic [3:0] {
        HEADER, ADDR_H, ADDR_L, LEN_H, LEN_L, WR_DATA, RD_REQ, RD_WAIT, RD_PUSH
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] addr;
    logic [16:0] count;
    logic        inc_en;
    logic        is_read;
    logic        ready_q;
    logic        wr_q;
    logic [7:0]  wr_val_q;
    logic [7:0]  rd_val_q;
    logic        err_q;

    logic        in_hs;
    logic        out_hs;
    logic        last;
    logic [7:0]  din;

    assign din    = bus.s_axis_tdata;
    assign in_hs  = bus.s_axis_tvalid & ready_q;
    assign out_hs = (state == RD_PUSH) & bus.m_axis_tready;
    assign last   = (count == 17'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            HEADER:  if (in_hs && din[7]) state_nxt = ADDR_H;
            ADDR_H:  if (in_hs) state_nxt = ADDR_L;
            ADDR_L:  if (in_hs) state_nxt = LEN_H;
            LEN_H:   if (in_hs) state_nxt = LEN_L;
            LEN_L:   if (in_hs) state_nxt = is_read ? RD_REQ : WR_DATA;
            WR_DATA: if (in_hs && last) state_nxt = HEADER;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (bus.rfg_read_valid) state_nxt = RD_PUSH;
            RD_PUSH: if (out_hs) state_nxt = last ? HEADER : RD_REQ;
            default: state_nxt = HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HEADER;
            addr     <= 16'd0;
            count    <= 17'd0;
            inc_en   <= 1'b0;
            is_read  <= 1'b0;
            ready_q  <= 1'b0;
            wr_q     <= 1'b0;
            wr_val_q <= 8'd0;
            rd_val_q <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            // Write-path increment lands one cycle after the strobe, so the strobe sees the pre-increment address.
            if (wr_q && inc_en)
                addr <= addr + 16'd1;
            case (state)
                HEADER: if (in_hs) begin
                    inc_en  <= din[0];
                    is_read <= din[6];
                    err_q   <= (din[7:6] == 2'b01);
                end
                ADDR_H:  if (in_hs) addr[15:8] <= din;
                ADDR_L:  if (in_hs) addr[7:0] <= din;
                LEN_H:   if (in_hs) count <= {1'b0, din, 8'h00};
                LEN_L:   if (in_hs) count <= {1'b0, count[15:8], din} + 17'd1;
                WR_DATA: if (in_hs) begin
                    wr_q     <= 1'b1;
                    wr_val_q <= din;
                    count    <= count - 17'd1;
                end
                RD_WAIT: if (bus.rfg_read_valid) rd_val_q <= bus.rfg_read_value;
                RD_PUSH: if (out_hs) begin
                    count <= count - 17'd1;
                    if (inc_en)
                        addr <= addr + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_axis_tready   = ready_q;
    assign bus.m_axis_tdata    = rd_val_q;
    assign bus.m_axis_tvalid   = (state == RD_PUSH);
    assign bus.rfg_address     = addr[ADDR_WIDTH-1:0];
    assign bus.rfg_write_value = wr_val_q;
    assign bus.rfg_write       = wr_q;
    assign bus.rfg_read        = (state == RD_REQ);
    assign busy                = (state != HEADER);
    assign err_bad_header      = err_q;

endmodule

// File: tb/tb_rfg_axis_cmd_decoder.sv
// Directed bench for rfg_axis_cmd_decoder: table of write frames plus hand-written read/reset/error sequences.
module tb_rfg_axis_cmd_decoder;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err;

    rfg_axis_cmd_decoder_if #(.ADDR_WIDTH(AW)) bus ();

    rfg_axis_cmd_decoder #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .err_bad_header (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wq_a[$];
    logic [7:0]    wq_d[$];
    logic [AW-1:0] rq_a[$];
    logic [7:0]    mq[$];
    logic [7:0]    resp_q[$];
    int            errn = 0;

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] addr;
        int          n;
        logic [23:0] data;
        logic [23:0] eaddr;
    } wvec_t;

    wvec_t vec[5];

    // Observation of DUT outputs mid-cycle; tb inputs only change at posedge+1.
    always @(negedge clk) begin
        if (bus.rfg_write === 1'b1) begin
            wq_a.push_back(bus.rfg_address);
            wq_d.push_back(bus.rfg_write_value);
        end
        if (bus.rfg_read === 1'b1)
            rq_a.push_back(bus.rfg_address);
        if (err === 1'b1)
            errn++;
        if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1)
            mq.push_back(bus.m_axis_tdata);
    end

    // Register-file responder: data valid two cycles after each read strobe.
    initial begin
        bus.rfg_read_valid = 1'b0;
        bus.rfg_read_value = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.rfg_read_valid = 1'b0;
            if (bus.rfg_read === 1'b1) begin
                repeat (2) begin @(posedge clk); #1; end
                bus.rfg_read_valid = 1'b1;
                bus.rfg_read_value = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hEE;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        bus.s_axis_tdata  = b;
        bus.s_axis_tvalid = 1'b1;
        while (bus.s_axis_tready !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50)
            chk("s_axis_tready timeout", {31'd0, bus.s_axis_tready}, 32'd1);
        tick();
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [15:0] a, input logic [15:0] len);
        send_byte(hdr);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic clear();
        wq_a.delete();
        wq_d.delete();
        rq_a.delete();
        mq.delete();
        errn = 0;
    endtask

    task automatic wait_mq(input int n);
        int g = 0;
        while (mq.size() < n && g < 200) begin
            tick();
            g++;
        end
    endtask

    initial begin
        vec[0] = '{hdr: 8'h81, addr: 16'h0010, n: 3, data: 24'hAABBCC, eaddr: 24'h101112};
        vec[1] = '{hdr: 8'h80, addr: 16'h0020, n: 2, data: 24'h112200, eaddr: 24'h202000};
        vec[2] = '{hdr: 8'h81, addr: 16'h00FF, n: 2, data: 24'h556600, eaddr: 24'hFF0000};
        vec[3] = '{hdr: 8'hBF, addr: 16'h1234, n: 1, data: 24'h770000, eaddr: 24'h340000};
        vec[4] = '{hdr: 8'h80, addr: 16'h0040, n: 3, data: 24'h010203, eaddr: 24'h404040};

        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("reset s_axis_tready", {31'd0, bus.s_axis_tready}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rfg_write", {31'd0, bus.rfg_write}, 32'd0);
        chk("reset rfg_read", {31'd0, bus.rfg_read}, 32'd0);
        chk("reset m_axis_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
        chk("reset err_bad_header", {31'd0, err}, 32'd0);
        chk("reset rfg_address", 32'(bus.rfg_address), 32'd0);
        rst = 1'b0;
        tick();
        chk("tready after reset", {31'd0, bus.s_axis_tready}, 32'd1);

        // Table-driven write frames
        for (int i = 0; i < 5; i++) begin
            clear();
            send_frame(vec[i].hdr, vec[i].addr, 16'(vec[i].n - 1));
            for (int j = 0; j < vec[i].n; j++)
                send_byte(vec[i].data[23 - 8*j -: 8]);
            repeat (3) tick();
            chk($sformatf("vec%0d write count", i), 32'(wq_a.size()), 32'(vec[i].n));
            for (int j = 0; j < vec[i].n; j++) begin
                if (j < wq_a.size()) begin
                    chk($sformatf("vec%0d addr%0d", i, j), 32'(wq_a[j]), 32'(vec[i].eaddr[23 - 8*j -: 8]));
                    chk($sformatf("vec%0d data%0d", i, j), 32'(wq_d[j]), 32'(vec[i].data[23 - 8*j -: 8]));
                end
            end
            chk($sformatf("vec%0d busy after", i), {31'd0, busy}, 32'd0);
            chk($sformatf("vec%0d no read", i), 32'(rq_a.size()), 32'd0);
        end

        // Write latency and address increment timing
        clear();
        send_frame(8'h81, 16'h0070, 16'h0000);
        send_byte(8'h42);
        chk("latency rfg_write", {31'd0, bus.rfg_write}, 32'd1);
        chk("latency rfg_address", 32'(bus.rfg_address), 32'h70);
        chk("latency rfg_write_value", 32'(bus.rfg_write_value), 32'h42);
        chk("latency busy", {31'd0, busy}, 32'd0);
        tick();
        chk("latency strobe width", {31'd0, bus.rfg_write}, 32'd0);
        chk("latency addr inc", 32'(bus.rfg_address), 32'h71);

        // Two-byte auto-increment read
        clear();
        resp_q.delete();
        resp_q.push_back(8'h5A);
        resp_q.push_back(8'hA5);
        bus.m_axis_tready = 1'b1;
        send_frame(8'hC1, 16'h0005, 16'h0001);
        wait_mq(2);
        tick();
        chk("read m count", 32'(mq.size()), 32'd2);
        chk("read req count", 32'(rq_a.size()), 32'd2);
        if (rq_a.size() == 2) begin
            chk("read addr0", 32'(rq_a[0]), 32'h05);
            chk("read addr1", 32'(rq_a[1]), 32'h06);
        end
        if (mq.size() == 2) begin
            chk("read data0", 32'(mq[0]), 32'h5A);
            chk("read data1", 32'(mq[1]), 32'hA5);
        end
        chk("read busy after", {31'd0, busy}, 32'd0);
        chk("read no writes", 32'(wq_a.size()), 32'd0);

        // Read with egress stalled for 10 cycles
        clear();
        resp_q.delete();
        resp_q.push_back(8'h3C);
        bus.m_axis_tready = 1'b0;
        send_frame(8'hC0, 16'h0008, 16'h0000);
        for (int g = 0; g < 50 && bus.m_axis_tvalid !== 1'b1; g++)
            tick();
        chk("stall tvalid rise", {31'd0, bus.m_axis_tvalid}, 32'd1);
        repeat (10) tick();
        chk("stall tvalid held", {31'd0, bus.m_axis_tvalid}, 32'd1);
        chk("stall tdata held", 32'(bus.m_axis_tdata), 32'h3C);
        chk("stall read count", 32'(rq_a.size()), 32'd1);
        bus.m_axis_tready = 1'b1;
        tick();
        tick();
        chk("stall m count", 32'(mq.size()), 32'd1);
        if (mq.size() == 1)
            chk("stall data", 32'(mq[0]), 32'h3C);
        chk("stall busy after", {31'd0, busy}, 32'd0);

        // Filler bytes and reserved header
        clear();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h40);
        chk("bad header pulse", {31'd0, err}, 32'd1);
        chk("bad header busy", {31'd0, busy}, 32'd0);
        send_frame(8'h80, 16'h0030, 16'h0000);
        send_byte(8'h99);
        repeat (3) tick();
        chk("bad header err count", 32'(errn), 32'd1);
        chk("bad header write count", 32'(wq_a.size()), 32'd1);
        if (wq_a.size() == 1) begin
            chk("bad header write addr", 32'(wq_a[0]), 32'h30);
            chk("bad header write data", 32'(wq_d[0]), 32'h99);
        end

        // Reset in the middle of a frame
        clear();
        send_byte(8'h81);
        send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h00);
        rst = 1'b1;
        tick();
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset tready", {31'd0, bus.s_axis_tready}, 32'd0);
        chk("midreset rfg_write", {31'd0, bus.rfg_write}, 32'd0);
        rst = 1'b0;
        tick();
        chk("midreset tready back", {31'd0, bus.s_axis_tready}, 32'd1);
        send_frame(8'h80, 16'h0060, 16'h0000);
        send_byte(8'hEE);
        repeat (3) tick();
        chk("midreset write count", 32'(wq_a.size()), 32'd1);
        if (wq_a.size() == 1) begin
            chk("midreset write addr", 32'(wq_a[0]), 32'h60);
            chk("midreset write data", 32'(wq_d[0]), 32'hEE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
